// File: rtl/sc_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sc_window_ctrl
//  Purpose  : Runs one stochastic-computing evaluation window. On start it
//             clears the ones accumulator, enables the upstream bitstream
//             datapath for exactly L cycles and counts the ones it returns.
//             The result is then held behind a valid/ready handshake.
//  Ports    : clk, rst        - clock / async active-high reset
//             start, len      - request a window of length len (0 = 2^LEN_W)
//             abort           - cancel the window and discard its result
//             bit_in          - stochastic bit, sampled while stream_en=1
//             stream_en       - datapath enable (decoded from state)
//             busy            - high in CLEAR, RUN and DONE
//             out_valid/ready - result handshake
//             out_count       - saturating count of ones in the window
//             out_sat         - sticky flag: the accumulator saturated
//  Revision : 1.0  initial release
// ============================================================================
module sc_window_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    input  logic             bit_in,
    output logic             stream_en,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_count,
    output logic             out_sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] C_ACC_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ACC_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_W:0]   C_REM_ONE  = {{LEN_W{1'b0}}, 1'b1};
    // A zero length field encodes the largest window, 2^LEN_W.
    localparam logic [LEN_W:0]   C_REM_FULL = {1'b1, {LEN_W{1'b0}}};

    state_t           state_q, state_d;
    logic [LEN_W:0]   rem_q,   rem_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             sat_q,   sat_d;

    logic             w_accept;
    logic [LEN_W:0]   w_len_ext;

    // A new window may start from IDLE, or straight out of DONE when the
    // consumer takes the current result in the same cycle (no IDLE gap).
    assign w_accept  = start && !abort &&
                       ((state_q == S_IDLE) || ((state_q == S_DONE) && out_ready));
    assign w_len_ext = (len == '0) ? C_REM_FULL : {1'b0, len};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        acc_d   = acc_q;
        sat_d   = sat_q;

        if (abort) begin
            // Result registers keep their last value; only the handshake drops.
            state_d = S_IDLE;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        state_d = S_CLEAR;
                        rem_d   = w_len_ext;
                    end
                end
                S_CLEAR: begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    state_d = S_RUN;
                end
                S_RUN: begin
                    rem_d = rem_q - C_REM_ONE;
                    if (bit_in) begin
                        // Saturate instead of wrapping; remember that it happened.
                        if (acc_q == C_ACC_MAX) begin
                            sat_d = 1'b1;
                        end else begin
                            acc_d = acc_q + C_ACC_ONE;
                        end
                    end
                    if (rem_q == C_REM_ONE) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            state_d = S_CLEAR;
                            rem_d   = w_len_ext;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
        end
    end

    // Control outputs are pure state decodes so reset removes them at once.
    assign stream_en = (state_q == S_RUN);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_count = acc_q;
    assign out_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_sc_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sc_window_ctrl
//  Purpose  : Self-checking bench for sc_window_ctrl (8/8 and 4/4 builds).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sc_window_ctrl;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit accumulator / 8-bit length instance
    logic       rst, start, abort, bit_in, out_ready;
    logic [7:0] len;
    logic       stream_en, busy, out_valid, out_sat;
    logic [7:0] out_count;

    // 4-bit accumulator / 4-bit length instance
    logic       start4, abort4, bit4, ready4;
    logic [3:0] len4;
    logic       stream4, busy4, valid4, sat4;
    logic [3:0] count4;

    sc_window_ctrl #(.WIDTH(8), .LEN_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
        .bit_in(bit_in), .stream_en(stream_en), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_count(out_count), .out_sat(out_sat)
    );

    sc_window_ctrl #(.WIDTH(4), .LEN_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .len(len4), .abort(abort4),
        .bit_in(bit4), .stream_en(stream4), .busy(busy4),
        .out_valid(valid4), .out_ready(ready4),
        .out_count(count4), .out_sat(sat4)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Assumes IDLE at a negedge; request is accepted at the next posedge,
    // returns at the negedge inside CLEAR.
    task automatic launch(input logic [7:0] lenenc);
        start = 1'b1;
        len   = lenenc;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Runs a window from the CLEAR cycle through the result handshake.
    // Expected result comes from a plain popcount clipped to 255.
    task automatic body(input int L, input bit use_pat, input logic [31:0] pat,
                        input int pct, input int hold, input bit chain,
                        input logic [7:0] chain_len, output int cnt, output int sat);
        int  ones;
        int  mdl_cnt;
        int  mdl_sat;
        logic b;
        ones = 0;
        chk("clear_busy", busy, 1);
        chk("clear_stream", stream_en, 0);
        chk("clear_valid", out_valid, 0);
        for (int i = 0; i < L; i++) begin
            @(negedge clk);
            chk("run_stream", stream_en, 1);
            chk("run_valid", out_valid, 0);
            b      = use_pat ? pat[i % 32] : ($urandom_range(99) < pct);
            bit_in = b;
            ones  += int'(b);
        end
        @(negedge clk);
        bit_in  = 1'b0;
        mdl_cnt = (ones > 255) ? 255 : ones;
        mdl_sat = (ones > 255) ? 1 : 0;
        chk("done_stream", stream_en, 0);
        chk("done_valid", out_valid, 1);
        chk("count", out_count, mdl_cnt);
        chk("sat", out_sat, mdl_sat);
        cnt = out_count;
        sat = out_sat;
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            start     = 1'($urandom_range(1));
            len       = 8'($urandom);
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_count", out_count, mdl_cnt);
            chk("hold_sat", out_sat, mdl_sat);
        end
        out_ready = 1'b1;
        start     = chain;
        len       = chain_len;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        if (chain) begin
            chk("b2b_busy", busy, 1);
            chk("b2b_stream", stream_en, 0);
            chk("b2b_valid", out_valid, 0);
        end else begin
            chk("idle_busy", busy, 0);
            chk("idle_valid", out_valid, 0);
        end
    endtask

    typedef struct {
        int          L;
        logic [7:0]  lenenc;
        logic [31:0] pat;
        int          exp_cnt;
        int          exp_sat;
        int          hold;
    } vec_t;

    vec_t vt[7];

    initial begin
        int   c, s, en_cycles, pct, hold, curL, nxtL;
        bit   seen_valid, ch, chained;
        logic [7:0] curE, nxtE;

        vt[0] = '{4,   8'd4,   32'h0000000D, 3,   0, 0};  // bits 1,0,1,1
        vt[1] = '{2,   8'd2,   32'h00000003, 2,   0, 5};  // backpressure hold
        vt[2] = '{1,   8'd1,   32'h00000001, 1,   0, 0};
        vt[3] = '{8,   8'd8,   32'h000000FF, 8,   0, 2};
        vt[4] = '{5,   8'd5,   32'h00000000, 0,   0, 1};
        vt[5] = '{255, 8'd255, 32'hFFFFFFFF, 255, 0, 0};  // reaches max, no overflow
        vt[6] = '{256, 8'd0,   32'hFFFFFFFF, 255, 1, 0};  // len=0 -> 256, saturates

        rst = 1'b1; start = 1'b0; abort = 1'b0; bit_in = 1'b0; out_ready = 1'b0; len = '0;
        start4 = 1'b0; abort4 = 1'b0; bit4 = 1'b0; ready4 = 1'b0; len4 = '0;
        repeat (2) @(negedge clk);
        chk("rst_stream", stream_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_count", out_count, 0);
        chk("rst_sat", out_sat, 0);
        chk("rst4_busy", busy4, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed windows from the table
        for (int v = 0; v < 7; v++) begin
            launch(vt[v].lenenc);
            body(vt[v].L, 1'b1, vt[v].pat, 0, vt[v].hold, 1'b0, 8'd0, c, s);
            chk("vec_cnt", c, vt[v].exp_cnt);
            chk("vec_sat", s, vt[v].exp_sat);
        end

        // 4-bit build: len=0 means 16 cycles, all ones saturates at 15
        start4 = 1'b1; len4 = 4'd0;
        @(negedge clk);
        start4 = 1'b0; bit4 = 1'b1;
        en_cycles = 0;
        repeat (24) begin
            @(negedge clk);
            if (stream4) en_cycles++;
        end
        chk("w4_en_cycles", en_cycles, 16);
        chk("w4_valid", valid4, 1);
        chk("w4_count", count4, 15);
        chk("w4_sat", sat4, 1);
        ready4 = 1'b1; bit4 = 1'b0;
        @(negedge clk);
        ready4 = 1'b0;
        chk("w4_idle", busy4, 0);

        // Abort on the third RUN cycle of an 8-cycle window
        launch(8'd8);
        @(negedge clk); bit_in = 1'b1;
        @(negedge clk); bit_in = 1'b1;
        @(negedge clk); bit_in = 1'b0; abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        chk("abort_stream", stream_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_count_kept", out_count, 2);
        seen_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        chk("abort_no_valid", int'(seen_valid), 0);
        launch(8'd1);
        body(1, 1'b1, 32'h1, 0, 0, 1'b0, 8'd0, c, s);
        chk("after_abort_cnt", c, 1);

        // Back-to-back: accept a new window in the same cycle as the result
        launch(8'd2);
        body(2, 1'b1, 32'h3, 0, 1, 1'b1, 8'd3, c, s);
        chk("b2b_first", c, 2);
        body(3, 1'b1, 32'h5, 0, 0, 1'b0, 8'd0, c, s);
        chk("b2b_second", c, 2);

        // start together with abort in IDLE is dropped
        start = 1'b1; abort = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", busy, 0);
        @(negedge clk);
        chk("start_abort_busy2", busy, 0);

        // Asynchronous reset in the middle of RUN
        launch(8'd10);
        bit_in = 1'b1;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_stream", stream_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_count", out_count, 0);
        chk("arst_sat", out_sat, 0);
        @(negedge clk);
        rst = 1'b0; bit_in = 1'b0;
        @(negedge clk);
        chk("arst_idle", busy, 0);

        // Randomized windows vs. popcount model
        curL = $urandom_range(1, 40);
        curE = 8'(curL);
        chained = 1'b0;
        for (int w = 0; w < 1000; w++) begin
            if (!chained) launch(curE);
            if ($urandom_range(99) < 3) begin
                nxtL = 256; nxtE = 8'd0;
            end else begin
                nxtL = $urandom_range(1, 40); nxtE = 8'(nxtL);
            end
            case ($urandom_range(3))
                0:       pct = 0;
                1:       pct = 50;
                2:       pct = 100;
                default: pct = 90;
            endcase
            hold = $urandom_range(0, 3);
            ch   = (w < 999) && ($urandom_range(3) == 0);
            body(curL, 1'b0, 32'h0, pct, hold, ch, nxtE, c, s);
            chained = ch;
            curL = nxtL;
            curE = nxtE;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
